uart_tx_sched: RTL
==================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter: HOLD_TIMEOUT, default 1023, max idle clk cycles a locked requester may stall a packet before forced release.
REQ-002 Ports: clk  input  1  system clock; all logic on posedge clk.
REQ-003 Ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Ports: req  input  4  per-requester byte-valid; req[i] held high until ack[i].
REQ-005 Ports: req_data  input  32  byte of requester i on bits [8i+7:8i].
REQ-006 Ports: req_last  input  4  req_last[i] high marks the presented byte as last of packet i.
REQ-007 Ports: ack  output  4  one-cycle pulse, byte of requester i accepted.
REQ-008 Ports: tx_data  output  8  byte driven to shared UART transmitter, stable from tx_start until next tx_start.
REQ-009 Ports: tx_start  output  1  one-cycle pulse launching one UART frame.
REQ-010 Ports: tx_busy  input  1  transmitter busy; rises after tx_start, falls after stop bit.
REQ-011 Ports: gnt_valid  output  1  a packet owner is locked; gnt_id  output  2  index of owner.
REQ-012 Ports: timeout  output  1  one-cycle pulse on forced release of a stalled owner.

Function
REQ-013 States SHALL be IDLE, WAIT_BUSY, WAIT_DONE, HOLD; encoding free.
REQ-014 IDLE: when |req and tx_busy=0, winner SHALL be first set req bit scanning ptr, ptr+1, ... mod 4.
REQ-015 On IDLE launch, same clock edge SHALL register tx_data=winner byte, tx_start=1, ack[winner]=1, gnt_id=winner, gnt_valid=1, lock flag=req_last[winner]; next state WAIT_BUSY.
REQ-016 Latency: req sampled high in IDLE at edge n -> tx_start and ack high during cycle n+1.
REQ-017 tx_start and ack SHALL each be high exactly one cycle per byte and always coincide; at most one ack bit high.
REQ-018 WAIT_BUSY: tx_busy=1 -> WAIT_DONE; no timeout in this state.
REQ-019 WAIT_DONE: tx_busy=0 and stored last=1 -> IDLE, gnt_valid=0, ptr=gnt_id+1 mod 4.
REQ-020 WAIT_DONE: tx_busy=0 and stored last=0 -> HOLD, hold counter cleared.
REQ-021 HOLD: req[gnt_id]=1 -> launch byte of gnt_id per REQ-015 (same latency), other requesters ignored, counter cleared.
REQ-022 HOLD: req[gnt_id]=0 -> counter increments; counter reaching HOLD_TIMEOUT -> timeout pulse, gnt_valid=0, ptr=gnt_id+1 mod 4, IDLE.
REQ-023 Hold counter SHALL be wide enough for HOLD_TIMEOUT without wrap; counter held at 0 outside HOLD.
REQ-024 Requests from non-owners SHALL wait, without ack, while gnt_valid=1.
REQ-025 Owner deasserting then reasserting req within timeout SHALL continue the same packet.
REQ-026 tx_busy=1 while in IDLE SHALL block launch until it falls.
REQ-027 Single-byte packet (req_last=1 on first byte) SHALL return to IDLE after that frame, advancing ptr.
REQ-028 Timeout and an owner req arriving in the same cycle: the req SHALL win (launch, no timeout pulse).

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, ptr=0, tx_start=0, ack=0, tx_data=0, gnt_valid=0, gnt_id=0, timeout=0, counter=0.
REQ-030 Reset mid-packet SHALL drop the lock; after release, arbitration restarts from requester 0.
REQ-031 First launch after rst_n rises SHALL occur no earlier than the second posedge clk.

Verification
REQ-032 All four req high, last=1, ptr=0 -> grant order 0,1,2,3, one tx_start per frame, ack matching.
REQ-033 Req1 sends 3-byte packet 0xA1,0xA2,0xA3 (last on 0xA3) while req2 constantly high -> tx_data sequence A1,A2,A3 before any req2 byte.
REQ-034 Owner 2 stalls after byte 1, HOLD_TIMEOUT=8 -> timeout pulse 8 cycles after entering HOLD, next grant to requester 3 if requesting.
REQ-035 rst_n pulsed low during WAIT_DONE of owner 3 -> all outputs 0 that cycle; post-reset req0 and req3 high -> requester 0 granted first.
REQ-036 tx_busy held high in IDLE with req0 high -> no tx_start until tx_busy falls, then tx_start one cycle later.
REQ-037 Owner req reasserted in the exact cycle counter reaches HOLD_TIMEOUT -> byte launched, timeout stays 0.

Source files
------------

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: four-way packet-locking round-robin scheduler
// feeding one shared UART transmitter.
module uart_tx_sched #(
  parameter int HOLD_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_last,
  output logic [3:0]  ack,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        gnt_valid,
  output logic [1:0]  gnt_id,
  output logic        timeout
);

  localparam int CW =
    (HOLD_TIMEOUT < 1) ? 1 : $clog2(HOLD_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_END = CW'(HOLD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE,
    HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic [3:0]    ack_q, ack_d;
  logic          gnt_valid_q, gnt_valid_d;
  logic [1:0]    gnt_id_q, gnt_id_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          arm_q, arm_d;

  logic          win_found;
  logic [1:0]    win_id;
  logic          launch;
  logic [1:0]    lid;

  // Lowest rotation offset from ptr wins, so scan downward.
  always_comb begin
    win_found = 1'b0;
    win_id    = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr_q + 2'(k)]) begin
        win_found = 1'b1;
        win_id    = ptr_q + 2'(k);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    ack_d       = 4'b0000;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    timeout_d   = 1'b0;
    cnt_d       = '0;
    last_d      = last_q;
    arm_d       = 1'b1;
    launch      = 1'b0;
    lid         = gnt_id_q;

    unique case (state_q)
      IDLE: begin
        // arm_q keeps the first edge after reset from launching
        if (arm_q && win_found && !tx_busy) begin
          launch = 1'b1;
          lid    = win_id;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            state_d     = IDLE;
            gnt_valid_d = 1'b0;
            ptr_d       = gnt_id_q + 2'd1;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (req[gnt_id_q]) begin
          launch = 1'b1;
        end else if (cnt_q == CNT_END) begin
          timeout_d   = 1'b1;
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_id_q + 2'd1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      tx_data_d   = req_data[{lid, 3'b000} +: 8];
      tx_start_d  = 1'b1;
      ack_d[lid]  = 1'b1;
      gnt_id_d    = lid;
      gnt_valid_d = 1'b1;
      last_d      = req_last[lid];
      state_d     = WAIT_BUSY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      tx_data_q   <= 8'h00;
      tx_start_q  <= 1'b0;
      ack_q       <= 4'b0000;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= 2'd0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      arm_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      ack_q       <= ack_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      arm_q       <= arm_d;
    end
  end

  assign ack       = ack_q;
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign timeout   = timeout_q;

endmodule
